// File: rtl/alu_pkg.sv
// Shared op codes, FSM state types and helpers for the multi-cycle MIPS ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1010;
  localparam logic [3:0] OP_PASSB = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} alu_state_e;
  typedef enum logic [1:0] {MdIdle, MdRun, MdFix} md_phase_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the control unit and the multi-cycle ALU.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             sign;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, ALUOp, regA, regB,
    input  ready, done, result, zero, sign, overflow, hi, lo
  );

  modport slave (
    input  start, ALUOp, regA, regB,
    output ready, done, result, zero, sign, overflow, hi, lo
  );
endinterface

// File: rtl/mul_div_iter.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with a final sign fix-up.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             fin_o
);
  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CntOne = CW'(1);

  md_phase_e        phase_q, phase_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_wide_q, neg_wide_d, neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod_neg;

  assign a_neg    = is_signed_i & a_i[MSB];
  assign b_neg    = is_signed_i & b_i[MSB];
  assign a_mag    = a_neg ? -a_i : a_i;
  assign b_mag    = b_neg ? -b_i : b_i;
  assign step_sum = {1'b0, hi_q} + {1'b0, mag_q};
  assign rem_sh   = {hi_q, lo_q[MSB]};
  assign rem_diff = rem_sh - {1'b0, mag_q};
  assign prod_neg = -{hi_q, lo_q};

  always_comb begin
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    mag_d      = mag_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_wide_d = neg_wide_q;
    neg_hi_d   = neg_hi_q;
    neg_lo_d   = neg_lo_q;
    case (phase_q)
      MdIdle: begin
        if (go_i) begin
          if (is_div_i && b_i == '0) begin
            // Divide by zero: no iterations, report dividend as remainder and all-ones quotient.
            phase_d    = MdFix;
            div_d      = 1'b1;
            hi_d       = a_i;
            lo_d       = '1;
            neg_wide_d = 1'b0;
            neg_hi_d   = 1'b0;
            neg_lo_d   = 1'b0;
          end else begin
            phase_d    = MdRun;
            cnt_d      = CntMax;
            div_d      = is_div_i;
            hi_d       = '0;
            mag_d      = is_div_i ? b_mag : a_mag;
            lo_d       = is_div_i ? a_mag : b_mag;
            neg_wide_d = ~is_div_i & (a_neg ^ b_neg);
            neg_lo_d   = is_div_i & (a_neg ^ b_neg);
            neg_hi_d   = is_div_i & a_neg;
          end
        end
      end
      MdRun: begin
        if (div_q) begin
          if (!rem_diff[WIDTH]) begin
            hi_d = rem_diff[MSB:0];
            lo_d = {lo_q[MSB-1:0], 1'b1};
          end else begin
            hi_d = rem_sh[MSB:0];
            lo_d = {lo_q[MSB-1:0], 1'b0};
          end
        end else if (lo_q[0]) begin
          {hi_d, lo_d} = {step_sum, lo_q[MSB:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[MSB:1]};
        end
        cnt_d = cnt_q - CntOne;
        if (cnt_q == '0) phase_d = MdFix;
      end
      MdFix:   phase_d = MdIdle;
      default: phase_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q    <= MdIdle;
      cnt_q      <= '0;
      div_q      <= 1'b0;
      mag_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_wide_q <= 1'b0;
      neg_hi_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      mag_q      <= mag_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_wide_q <= neg_wide_d;
      neg_hi_q   <= neg_hi_d;
      neg_lo_q   <= neg_lo_d;
    end
  end

  // Low in the final iteration so the parent FSM can move to FIX on the same edge.
  assign busy_o = (phase_q == MdRun) && (cnt_q != '0);
  assign fin_o  = (phase_q == MdFix);
  assign hi_o   = neg_wide_q ? prod_neg[2*WIDTH-1:WIDTH] : (neg_hi_q ? -hi_q : hi_q);
  assign lo_o   = neg_wide_q ? prod_neg[WIDTH-1:0] : (neg_lo_q ? -lo_q : lo_q);

endmodule

// File: rtl/alu_multicycle.sv
// MIPS ALU: single-cycle ops plus iterative MULT/DIV with HI/LO, behind a start/done handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_multicycle_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_ovf;
  logic [SHW-1:0]   shamt;
  logic             md_go, md_busy, md_fin;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign shamt = bus.regA[SHW-1:0];
  assign sum   = bus.regA + bus.regB;
  assign diff  = bus.regA - bus.regB;
  assign md_go = (state_q == StIdle) && bus.start && is_multicycle(bus.ALUOp);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUOp)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.regA[MSB] == bus.regB[MSB]) && (sum[MSB] != bus.regA[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.regA[MSB] != bus.regB[MSB]) && (diff[MSB] != bus.regA[MSB]);
      end
      OP_SLL:   alu_res = bus.regB << shamt;
      OP_OR:    alu_res = bus.regA | bus.regB;
      OP_AND:   alu_res = bus.regA & bus.regB;
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, bus.regA < bus.regB};
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.regA) < $signed(bus.regB)};
      OP_XOR:   alu_res = bus.regA ^ bus.regB;
      OP_SRL:   alu_res = bus.regB >> shamt;
      OP_SRA:   alu_res = $signed(bus.regB) >>> shamt;
      OP_NOR:   alu_res = ~(bus.regA | bus.regB);
      OP_PASSB: alu_res = bus.regB;
      default:  alu_res = '0;
    endcase
  end

  mul_div_iter #(
    .WIDTH(WIDTH)
  ) u_mul_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .go_i       (md_go),
    .is_div_i   (bus.ALUOp[1]),
    .is_signed_i(~bus.ALUOp[0]),
    .a_i        (bus.regA),
    .b_i        (bus.regB),
    .busy_o     (md_busy),
    .hi_o       (md_hi),
    .lo_o       (md_lo),
    .fin_o      (md_fin)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (is_multicycle(bus.ALUOp)) begin
            state_d = (bus.ALUOp[1] && bus.regB == '0) ? StFix : StRun;
          end else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            state_d  = StDone;
          end
        end
      end
      StRun: if (!md_busy) state_d = StFix;
      StFix: begin
        if (md_fin) begin
          hi_d     = md_hi;
          lo_d     = md_lo;
          result_d = md_lo;
          ovf_d    = 1'b0;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready    = (state_q == StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.result   = result_q;
  assign bus.zero     = (result_q == '0);
  assign bus.sign     = result_q[MSB];
  assign bus.overflow = ovf_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; advances until done is seen or the cycle budget runs out.
  task automatic wait_done(inout int lat, inout bit rdy_low);
    while (!bus.done && lat < 100) begin
      if (bus.ready) rdy_low = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit rdy_low, output logic done_after);
    bus.start = 1'b1;
    bus.ALUOp = op;
    bus.regA  = a;
    bus.regB  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.ALUOp = OP_ADD;
    bus.regA  = 32'hDEAD_BEEF;
    bus.regB  = 32'h1234_5678;
    lat       = 1;
    rdy_low   = 1'b1;
    @(negedge clk);
    wait_done(lat, rdy_low);
    @(negedge clk);
    done_after = bus.done;
  endtask

  int   lat;
  bit   rdy_low;
  logic done_after;

  initial begin
    bus.start = 1'b0;
    bus.ALUOp = '0;
    bus.regA  = '0;
    bus.regB  = '0;

    #1 reset = 1'b1;
    #2;
    chk("rst ready", bus.ready, 1);
    chk("rst done", bus.done, 0);
    chk("rst result", bus.result, 0);
    chk("rst zero", bus.zero, 1);
    chk("rst hi", bus.hi, 0);
    chk("rst lo", bus.lo, 0);
    chk("rst overflow", bus.overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat, rdy_low, done_after);
    chk("add latency", lat, 1);
    chk("add result", bus.result, 64'h8000_0000);
    chk("add overflow", bus.overflow, 1);
    chk("add sign", bus.sign, 1);
    chk("add done pulse", done_after, 0);

    run_op(OP_SUB, 32'd5, 32'd5, lat, rdy_low, done_after);
    chk("sub result", bus.result, 0);
    chk("sub zero", bus.zero, 1);
    chk("sub overflow", bus.overflow, 0);

    run_op(OP_SRA, 32'd4, 32'hF000_0000, lat, rdy_low, done_after);
    chk("sra result", bus.result, 64'hFF00_0000);
    run_op(OP_SRL, 32'd4, 32'hF000_0000, lat, rdy_low, done_after);
    chk("srl result", bus.result, 64'h0F00_0000);
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1, lat, rdy_low, done_after);
    chk("sltu result", bus.result, 0);
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, lat, rdy_low, done_after);
    chk("slt result", bus.result, 1);
    run_op(OP_NOR, 32'hF0F0_0000, 32'h0000_00FF, lat, rdy_low, done_after);
    chk("nor result", bus.result, 64'h0F0F_FF00);
    chk("single op hi untouched", bus.hi, 0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, rdy_low, done_after);
    chk("mult latency", lat, 34);
    chk("mult ready low", rdy_low, 1);
    chk("mult hi", bus.hi, 64'hFFFF_FFFF);
    chk("mult lo", bus.lo, 64'hFFFF_FFEB);
    chk("mult result", bus.result, 64'hFFFF_FFEB);
    chk("mult done pulse", done_after, 0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rdy_low, done_after);
    chk("multu latency", lat, 34);
    chk("multu hi", bus.hi, 64'hFFFF_FFFE);
    chk("multu lo", bus.lo, 64'h0000_0001);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, rdy_low, done_after);
    chk("div latency", lat, 34);
    chk("div lo", bus.lo, 64'hFFFF_FFFD);
    chk("div hi", bus.hi, 64'hFFFF_FFFF);

    run_op(OP_DIVU, 32'd7, 32'd0, lat, rdy_low, done_after);
    chk("divu0 latency", lat, 2);
    chk("divu0 hi", bus.hi, 7);
    chk("divu0 lo", bus.lo, 64'hFFFF_FFFF);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, rdy_low, done_after);
    chk("div minneg lo", bus.lo, 64'h8000_0000);
    chk("div minneg hi", bus.hi, 0);
    chk("div minneg overflow", bus.overflow, 0);

    // An add request arriving mid-divide must be dropped.
    bus.start = 1'b1;
    bus.ALUOp = OP_DIVU;
    bus.regA  = 32'd100;
    bus.regB  = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat     = 1;
    rdy_low = 1'b1;
    @(negedge clk);
    repeat (4) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.ALUOp = OP_ADD;
    bus.regA  = 32'd1;
    bus.regB  = 32'd2;
    @(posedge clk);
    lat++;
    #1 bus.start = 1'b0;
    @(negedge clk);
    wait_done(lat, rdy_low);
    chk("stall divu latency", lat, 34);
    chk("stall ready low", rdy_low, 1);
    chk("stall divu lo", bus.lo, 14);
    chk("stall divu hi", bus.hi, 2);
    chk("stall divu result", bus.result, 14);
    @(negedge clk);
    chk("stall add ignored", bus.done, 0);

    run_op(OP_OR, 32'h0000_00F0, 32'h0000_000F, lat, rdy_low, done_after);
    chk("or result", bus.result, 64'hFF);
    chk("or keeps hi", bus.hi, 2);
    chk("or keeps lo", bus.lo, 14);

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1'b1;
    bus.ALUOp = OP_MULT;
    bus.regA  = 32'd3;
    bus.regB  = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst ready", bus.ready, 1);
    chk("midrst done", bus.done, 0);
    chk("midrst result", bus.result, 0);
    chk("midrst hi", bus.hi, 0);
    chk("midrst lo", bus.lo, 0);
    chk("midrst overflow", bus.overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA, lat, rdy_low, done_after);
    chk("post-rst mult latency", lat, 34);
    chk("post-rst mult hi", bus.hi, 0);
    chk("post-rst mult lo", bus.lo, 24);
    chk("post-rst mult result", bus.result, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised next-generation ALU for the MIPS datapath.
- Widens the 3-bit op set to 4 bits: adds logical/arithmetic right shift, NOR, signed overflow, and iterative MULT/MULTU/DIV/DIVU writing HI/LO registers.
- A start/done handshake lets the control unit stall on multi-cycle ops. Single-cycle ops complete in one clock.
- Sits between the register file / immediate mux and the writeback mux. HI/LO feed MFHI/MFLO.

Parameters:
- WIDTH, 32, data width; must be ≥4 and even.
- SHW, $clog2(WIDTH), derived localparam: shift-amount bits taken from regA[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; accepted only when ready=1
- ALUOp  input  4  operation code, sampled on accept
- regA  input  WIDTH  operand A / shift amount / dividend / multiplicand
- regB  input  WIDTH  operand B / value to shift / divisor / multiplier
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse when result/hi/lo are valid
- result  output  WIDTH  registered result; for ops 1100–1111 equals lo
- zero  output  1  result==0
- sign  output  1  result[WIDTH-1]
- overflow  output  1  signed overflow of add/sub; 0 for all other ops
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE; result, hi, lo, overflow, done = 0; ready=1.
  - Any in-flight op is abandoned.
- ALUOp encoding:
  - 0000 add, 0001 sub, 0010 sll (regB<<shamt), 0011 or
  - 0100 and, 0101 sltu, 0110 slt, 0111 xor
  - 1000 srl, 1001 sra, 1010 nor, 1011 pass regB
  - 1100 mult, 1101 multu, 1110 div, 1111 divu
- Arithmetic is modulo 2^WIDTH.
- slt/sltu return 1 or 0, zero-extended.
- overflow for add/sub follows the standard sign rule; it is registered with result.
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE + start with op <1100: compute into result, go to DONE. done is high the cycle after accept (latency 1).
  - IDLE + start with op ≥1100: latch operands.
    - Signed ops latch magnitudes plus result-sign bits.
    - Go to RUN with counter = WIDTH-1.
  - RUN, multiply: shift-add one bit per cycle.
  - RUN, divide: restoring division, one quotient bit per cycle.
  - RUN exits to FIX when counter==0 (exactly WIDTH RUN cycles).
  - FIX: negate lo/hi as required.
    - mult: negate the 2*WIDTH product if signs differ.
    - div: quotient negated if signs differ; remainder takes the dividend's sign.
    - Then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - Multi-cycle latency from the accept edge to done = WIDTH+2 cycles.
- Divide by zero (regB==0, div or divu): skip RUN and go straight to FIX → DONE (latency 2). Result: hi=regA, lo=all ones.
- DIV of most-negative by -1: lo=most-negative (wrap), hi=0. No trap.
- start while not IDLE is ignored; no queuing. ALUOp/regA/regB may change freely after accept.
- result, hi, lo hold their values until the next accepted op that writes them.
  - Single-cycle ops do not modify hi/lo.
  - Multi-cycle ops update result=lo at DONE.
- zero/sign are combinational from the result register.

Decomposition:
- Package alu_pkg:
  - 4-bit op code constants (OP_ADD … OP_DIVU)
  - FSM state enum
  - helper predicate is_multicycle(op)
- Sub-module mul_div_iter:
  - holds the WIDTH-cycle shift-add / restoring-divide datapath, counter, and sign fix-up
  - interface: go, is_div, is_signed, a, b → busy, hi, lo, fin
- alu_multicycle keeps the single-cycle ops, the FSM, and the output registers.

Test Plan (WIDTH=32):
- add 0x7FFFFFFF+1, start at T → done at T+1, result=0x80000000, overflow=1, sign=1; sub 5-5 → zero=1, overflow=0.
- sra regA=4, regB=0xF0000000 → 0xFF000000. srl → 0x0F000000. sltu 0xFFFFFFFF vs 1 → 0; slt → 1.
- mult -3 × 7 at T → done at T+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; multu 0xFFFFFFFF² → hi=0xFFFFFFFE, lo=0x00000001; ready low throughout.
- div -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 → done at T+2, hi=7, lo=0xFFFFFFFF; div 0x80000000 / -1 → lo=0x80000000, hi=0.
- Pulse start with add during RUN of a divu → ignored; divu result is correct; hi/lo are unchanged by a later single-cycle op.
- Assert reset at RUN cycle 10 → all outputs 0 and ready=1 immediately (async); a new mult accepted after release completes with correct values.
